// File: rtl/out_display_driver.sv
// -----------------------------------------------------------------------------
// out_display_driver
//
// Display stage for the CPU's 8-bit output register. The register value is
// converted to decimal with a sequential double-dabble converter (one shift per
// clock), then shown on four time-multiplexed 7-segment digits: sign, hundreds,
// tens, ones. Unsigned or two's-complement interpretation is selectable, as is
// leading-zero blanking.
//
// Parameters:
//   SCAN_DIV    clk cycles each digit stays enabled (>= 2)
//   ACTIVE_LOW  1 = seg, dp and digit_en are inverted at the pins (common anode)
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   value[7:0]     CPU output register value
//   signed_mode    1 = interpret value as two's complement
//   blank_leading  1 = blank leading zero digits
//   seg[6:0]       {g,f,e,d,c,b,a}, registered
//   dp             decimal point, always off, registered
//   digit_en[3:0]  one-hot digit select [0]=ones [1]=tens [2]=hundreds [3]=sign
//   busy           conversion in progress (SHIFT or DONE)
//   shown_value    value whose digits are currently latched for display
// -----------------------------------------------------------------------------
module out_display_driver #(
    parameter int SCAN_DIV   = 12000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       blank_leading,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en,
    output logic       busy,
    output logic [7:0] shown_value
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_INV  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]      EN_INV   = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Input stage
    logic [7:0]  value_q;
    logic        smode_q;

    // Converter
    state_t      state_reg;
    logic [8:0]  src_reg;       // {signed_mode, value} of the last loaded snapshot
    logic [7:0]  mag_reg;       // magnitude being shifted out MSB first
    logic [11:0] bcd_reg;
    logic [2:0]  iter_reg;
    logic        neg_work_reg;

    // Display registers
    logic [3:0]  hund_reg;
    logic [3:0]  tens_reg;
    logic [3:0]  ones_reg;
    logic        neg_reg;
    logic [7:0]  shown_reg;

    // Scan
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       idx_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [3:0]       en_reg;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    logic [11:0] bcd_adj;
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    logic [19:0] shift_next;
    assign shift_next = {bcd_adj, mag_reg} << 1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Input registers are deliberately not reset: they just track the pins, so
    // a value present during reset is converted right after release.
    always_ff @(posedge clk) begin
        value_q <= value;
        smode_q <= signed_mode;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            src_reg      <= '0;
            mag_reg      <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            neg_work_reg <= 1'b0;
            hund_reg     <= '0;
            tens_reg     <= '0;
            ones_reg     <= '0;
            neg_reg      <= 1'b0;
            shown_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Only a snapshot that differs from the displayed one is
                    // converted; changes during SHIFT/DONE are picked up here.
                    if ({smode_q, value_q} != src_reg) begin
                        src_reg <= {smode_q, value_q};
                        if (smode_q && value_q[7]) begin
                            // 8'h80 negates to 8'h80, i.e. magnitude 128.
                            mag_reg      <= ~value_q + 8'd1;
                            neg_work_reg <= 1'b1;
                        end else begin
                            mag_reg      <= value_q;
                            neg_work_reg <= 1'b0;
                        end
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg  <= shift_next[19:8];
                    mag_reg  <= shift_next[7:0];
                    iter_reg <= iter_reg + 3'd1;
                    if (iter_reg == 3'd7) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    hund_reg  <= bcd_reg[11:8];
                    tens_reg  <= bcd_reg[7:4];
                    ones_reg  <= bcd_reg[3:0];
                    neg_reg   <= neg_work_reg;
                    shown_reg <= src_reg[7:0];
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Logical (active-high) content for the digit currently indexed.
    logic [6:0] seg_logical;
    logic [3:0] en_logical;
    always_comb begin
        seg_logical = 7'h00;
        en_logical  = 4'b0001 << idx_reg;
        case (idx_reg)
            2'd0: seg_logical = seg7(ones_reg);
            2'd1: seg_logical = (blank_leading && hund_reg == 4'd0 && tens_reg == 4'd0)
                              ? 7'h00 : seg7(tens_reg);
            2'd2: seg_logical = (blank_leading && hund_reg == 4'd0)
                              ? 7'h00 : seg7(hund_reg);
            2'd3: seg_logical = neg_reg ? 7'h40 : 7'h00;
            default: seg_logical = 7'h00;
        endcase
    end

    // seg and digit_en are registered from the same index on the same edge,
    // so the pins never show one digit's pattern on another digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
            idx_reg <= '0;
            seg_reg <= SEG_INV;
            dp_reg  <= ACTIVE_LOW;
            en_reg  <= EN_INV;
        end else begin
            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                idx_reg <= idx_reg + 2'd1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
            seg_reg <= seg_logical ^ SEG_INV;
            dp_reg  <= ACTIVE_LOW;
            en_reg  <= en_logical ^ EN_INV;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign digit_en    = en_reg;
    assign busy        = (state_reg != IDLE);
    assign shown_value = shown_reg;

endmodule
